// File: rtl/sd_dat_scheduler.sv
// Round-robin scheduler sharing the SD DAT physical controller between DMA (req 0) and CPU (req 1).
// Latency: 2 cycles request-to-strobe; stalls in ACK until complete drops. Requests wait while busy (no preemption).
module sd_dat_scheduler #(
    parameter int          MAX_RETRY   = 2,
    parameter logic [15:0] TIMEOUT_MIN = 16'd16
) (
    input  logic        sd_clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [7:0]  req_blocks,
    input  logic [1:0]  req_multiple,
    input  logic [15:0] timeout_cfg,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic [1:0]  error,
    output logic        busy,
    input  logic        phys_serial_ready,
    input  logic        phys_complete,
    input  logic        phys_timeout,
    output logic        phys_strobe,
    output logic        phys_ack,
    output logic        phys_idle,
    output logic        phys_write,
    output logic [3:0]  phys_blocks,
    output logic        phys_multiple,
    output logic [15:0] phys_timeout_reg
);

    typedef enum logic [2:0] {
        IDLE, LOAD, STROBE, WAIT_DONE, ACK, RELEASE, ABORT, RETRY_WAIT
    } state_t;

    localparam logic [1:0] LP_MAX_RETRY = 2'(MAX_RETRY);

    state_t      r_state;
    logic        r_sel;
    logic        r_last_grant;
    logic [1:0]  r_retry_cnt;

    logic        w_win;
    logic [3:0]  w_win_blocks;
    logic [1:0]  w_win_mask;
    logic [1:0]  w_sel_mask;
    logic [15:0] w_timeout_clamped;

    // With both valid, the requester that did not win last time goes next.
    always_comb begin
        w_win             = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
        w_win_blocks      = w_win ? req_blocks[7:4] : req_blocks[3:0];
        w_win_mask        = w_win ? 2'b10 : 2'b01;
        w_sel_mask        = r_sel ? 2'b10 : 2'b01;
        w_timeout_clamped = (timeout_cfg < TIMEOUT_MIN) ? TIMEOUT_MIN : timeout_cfg;
    end

    // Output registers are loaded on the edge that enters the state they belong to,
    // so each pulse lines up with its state cycle.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            r_state          <= IDLE;
            r_sel            <= 1'b0;
            r_last_grant     <= 1'b1;
            r_retry_cnt      <= 2'd0;
            grant            <= 2'b00;
            done             <= 2'b00;
            error            <= 2'b00;
            busy             <= 1'b0;
            phys_strobe      <= 1'b0;
            phys_ack         <= 1'b0;
            phys_idle        <= 1'b0;
            phys_write       <= 1'b0;
            phys_blocks      <= 4'd0;
            phys_multiple    <= 1'b0;
            phys_timeout_reg <= 16'd0;
        end else begin
            grant       <= 2'b00;
            done        <= 2'b00;
            error       <= 2'b00;
            phys_strobe <= 1'b0;
            phys_idle   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if ((|req_valid) && phys_serial_ready) begin
                        r_state          <= LOAD;
                        r_sel            <= w_win;
                        r_last_grant     <= w_win;
                        r_retry_cnt      <= 2'd0;
                        busy             <= 1'b1;
                        grant            <= w_win_mask;
                        phys_write       <= req_write[w_win];
                        phys_blocks      <= w_win_blocks;
                        phys_multiple    <= req_multiple[w_win];
                        phys_timeout_reg <= w_timeout_clamped;
                        if (w_win_blocks == 4'd0)
                            error <= w_win_mask;
                    end
                end
                LOAD: begin
                    if (phys_blocks == 4'd0) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state     <= STROBE;
                        phys_strobe <= 1'b1;
                    end
                end
                STROBE: r_state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (phys_complete) begin
                        r_state  <= ACK;
                        phys_ack <= 1'b1;
                    end else if (phys_timeout) begin
                        r_state   <= ABORT;
                        phys_idle <= 1'b1;
                        if (r_retry_cnt >= LP_MAX_RETRY)
                            error <= w_sel_mask;
                    end
                end
                ACK: begin
                    if (!phys_complete) begin
                        r_state  <= RELEASE;
                        phys_ack <= 1'b0;
                        done     <= w_sel_mask;
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                ABORT: begin
                    if (r_retry_cnt < LP_MAX_RETRY) begin
                        r_state     <= RETRY_WAIT;
                        r_retry_cnt <= r_retry_cnt + 2'd1;
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                RETRY_WAIT: begin
                    if (phys_serial_ready && !phys_timeout) begin
                        r_state     <= STROBE;
                        phys_strobe <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_dat_scheduler.sv
// Directed bench for sd_dat_scheduler: handshake, round-robin, zero-block reject, retries, reset.
module tb_sd_dat_scheduler;

    logic        sd_clock;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [7:0]  req_blocks;
    logic [1:0]  req_multiple;
    logic [15:0] timeout_cfg;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [1:0]  error;
    logic        busy;
    logic        phys_serial_ready;
    logic        phys_complete;
    logic        phys_timeout;
    logic        phys_strobe;
    logic        phys_ack;
    logic        phys_idle;
    logic        phys_write;
    logic [3:0]  phys_blocks;
    logic        phys_multiple;
    logic [15:0] phys_timeout_reg;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int n_idle = 0;
    int n_done = 0;
    int n_err = 0;

    sd_dat_scheduler #(.MAX_RETRY(2), .TIMEOUT_MIN(16'd16)) dut (
        .sd_clock(sd_clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_blocks(req_blocks),
        .req_multiple(req_multiple), .timeout_cfg(timeout_cfg),
        .grant(grant), .done(done), .error(error), .busy(busy),
        .phys_serial_ready(phys_serial_ready), .phys_complete(phys_complete),
        .phys_timeout(phys_timeout), .phys_strobe(phys_strobe), .phys_ack(phys_ack),
        .phys_idle(phys_idle), .phys_write(phys_write), .phys_blocks(phys_blocks),
        .phys_multiple(phys_multiple), .phys_timeout_reg(phys_timeout_reg)
    );

    initial sd_clock = 1'b0;
    always #5 sd_clock = ~sd_clock;

    always @(negedge sd_clock) begin
        if (phys_strobe) n_strobe++;
        if (phys_idle)   n_idle++;
        if (|done)       n_done++;
        if (|error)      n_err++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] all_outs();
        return {grant, done, error, busy, phys_strobe, phys_ack, phys_idle,
                phys_write, phys_blocks, phys_multiple, phys_timeout_reg};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sd_clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0: return |grant;
            1: return phys_strobe;
            2: return |done;
            3: return phys_idle;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        int n = 0;
        while (!sig(which) && n < 500) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, sig(which)}, 32'd1);
    endtask

    int s0, i0, d0, e0;
    logic [1:0] exp_mask;

    initial begin
        reset = 1'b1;
        req_valid = 2'b00; req_write = 2'b00; req_blocks = 8'h00; req_multiple = 2'b00;
        timeout_cfg = 16'd100;
        phys_serial_ready = 1'b1; phys_complete = 1'b0; phys_timeout = 1'b0;
        tick(2);
        check("reset_outputs", all_outs(), 32'd0);
        reset = 1'b0;
        tick(1);

        // Single write from requester 0, blocks=3, multiple
        req_valid = 2'b01; req_write = 2'b01; req_blocks = 8'h03; req_multiple = 2'b01;
        tick(1);
        check("t1_grant", {30'd0, grant}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_desc", {26'd0, phys_write, phys_blocks, phys_multiple}, {26'd0, 1'b1, 4'd3, 1'b1});
        check("t1_tmo_reg", {16'd0, phys_timeout_reg}, 32'd100);
        req_valid = 2'b00; req_blocks = 8'h77; req_write = 2'b00;
        tick(1);
        check("t1_strobe", {30'd0, grant, phys_strobe}, 32'd1);
        tick(1);
        check("t1_strobe_one_cycle", {31'd0, phys_strobe}, 32'd0);
        tick(48);
        phys_complete = 1'b1;
        tick(1);
        check("t1_ack", {30'd0, phys_ack, |done}, 32'd2);
        tick(2);
        check("t1_ack_held", {30'd0, phys_ack, |done}, 32'd2);
        phys_complete = 1'b0;
        tick(1);
        check("t1_done", {29'd0, done, phys_ack}, {29'd0, 2'b01, 1'b0});
        tick(1);
        check("t1_idle", {29'd0, done, busy}, 32'd0);
        check("t1_latched", {27'd0, phys_write, phys_blocks}, {27'd0, 1'b1, 4'd3});

        // Timeout floor, then reset while waiting for the transfer
        timeout_cfg = 16'd5;
        req_valid = 2'b01; req_blocks = 8'h02;
        tick(1);
        check("t5_tmo_floor", {16'd0, phys_timeout_reg}, 32'd16);
        req_valid = 2'b00;
        tick(3);
        d0 = n_done; e0 = n_err;
        reset = 1'b1;
        tick(1);
        check("t5_reset_outputs", all_outs(), 32'd0);
        reset = 1'b0;
        tick(2);
        check("t5_no_pulses", n_done + n_err, d0 + e0);

        // Both requesters valid: three back-to-back transfers, grants 0,1,0
        timeout_cfg = 16'd100;
        req_write = 2'b10; req_blocks = 8'h21; req_multiple = 2'b00;
        req_valid = 2'b11;
        d0 = n_done;
        for (int k = 0; k < 3; k++) begin
            exp_mask = (k == 1) ? 2'b10 : 2'b01;
            wait_for(0, "t2_grant_seen");
            check("t2_grant_order", {30'd0, grant}, {30'd0, exp_mask});
            check("t2_no_overlap", n_done - d0, k);
            check("t2_desc", {27'd0, phys_write, phys_blocks},
                  (k == 1) ? {27'd0, 1'b1, 4'd2} : {27'd0, 1'b0, 4'd1});
            if (k == 2) req_valid = 2'b00;
            wait_for(1, "t2_strobe_seen");
            tick(3);
            phys_complete = 1'b1;
            tick(2);
            phys_complete = 1'b0;
            wait_for(2, "t2_done_seen");
            check("t2_done", {30'd0, done}, {30'd0, exp_mask});
        end
        tick(2);

        // Requester 1 read with zero blocks: rejected without strobing
        req_valid = 2'b10; req_write = 2'b00; req_blocks = 8'h01;
        s0 = n_strobe;
        tick(1);
        check("t3_grant_err", {28'd0, grant, error}, {28'd0, 2'b10, 2'b10});
        req_valid = 2'b00;
        tick(1);
        check("t3_busy_low", {29'd0, busy, error}, 32'd0);
        tick(3);
        check("t3_no_strobe", n_strobe, s0);

        // Requester 1 times out on every attempt
        req_valid = 2'b10; req_blocks = 8'h40;
        s0 = n_strobe; i0 = n_idle; d0 = n_done;
        tick(1);
        check("t4_grant", {30'd0, grant}, 32'd2);
        req_valid = 2'b00;
        for (int a = 0; a < 3; a++) begin
            wait_for(1, "t4_strobe_seen");
            tick(2);
            phys_timeout = 1'b1;
            wait_for(3, "t4_idle_seen");
            phys_timeout = 1'b0;
            check("t4_err_timing", {30'd0, error}, (a == 2) ? 32'd2 : 32'd0);
        end
        tick(1);
        check("t4_busy_low", {31'd0, busy}, 32'd0);
        tick(3);
        check("t4_strobes", n_strobe - s0, 3);
        check("t4_idles", n_idle - i0, 3);
        check("t4_no_done", n_done, d0);

        // Complete and timeout together: completion wins
        req_valid = 2'b01; req_blocks = 8'h01;
        i0 = n_idle;
        wait_for(0, "t6_grant_seen");
        check("t6_grant", {30'd0, grant}, 32'd1);
        req_valid = 2'b00;
        wait_for(1, "t6_strobe_seen");
        tick(1);
        phys_complete = 1'b1; phys_timeout = 1'b1;
        tick(1);
        check("t6_ack_path", {30'd0, phys_ack, phys_idle}, 32'd2);
        phys_complete = 1'b0; phys_timeout = 1'b0;
        tick(1);
        check("t6_done", {30'd0, done}, 32'd1);
        tick(2);
        check("t6_no_idle", n_idle, i0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
